iq_4sum: RTL and testbench
==========================

// Module: iq_4sum
// PURPOSE
// - Decimate-by-4 summer for a complex (I/Q) sample stream in the receive DSP chain.
// - Accepts strobed I/Q samples and adds each group of 4 consecutive accepted samples per channel.
// - Emits one summed I/Q pair plus a one-cycle strobe per group, so the output rate is input rate / 4.
// PARAMETERS
// - DATA_WIDTH  16  width of I/Q inputs and outputs (signed two's complement)
// PORTS
// - clk         in   1           system clock; all logic on the rising edge
// - rst         in   1           asynchronous, active-high reset
// - ce          in   1           clock enable; when 0 the block holds all state
// - strobe_in   in   1           input sample valid; a sample is accepted when ce=1 and strobe_in=1
// - I_in        in   DATA_WIDTH  signed in-phase sample
// - Q_in        in   DATA_WIDTH  signed quadrature sample
// - I4sum       out  DATA_WIDTH  signed sum of the last 4 accepted I samples (registered)
// - Q4sum       out  DATA_WIDTH  signed sum of the last 4 accepted Q samples (registered)
// - strobe_out  out  1           one-cycle pulse: a new I4sum/Q4sum pair is valid
// BEHAVIOUR
// - Reset (async, rst=1): I4sum=0, Q4sum=0, strobe_out=0, 2-bit phase counter=0, accumulators=0.
// - Internal accumulators are DATA_WIDTH+2 bits wide and sign-extend each input, so there is no internal overflow.
// - Accept edge (ce=1, strobe_in=1):
//   - phase 0: acc <= sample (restart).
//   - phases 1..2: acc <= acc + sample.
//   - phase 3: outputs <= fmt(acc + sample); strobe_out <= 1; acc cleared.
//   - The phase counter increments mod 4 on every accepted sample.
// - Latency: the outputs and strobe_out update on the same edge that accepts the 4th sample.
//   - strobe_out is high for exactly 1 clk, then 0 on the next edge.
//   - I4sum/Q4sum hold their value until the next group completes.
// - ce=1, strobe_in=0: strobe_out <= 0; accumulators, counter and outputs hold.
// - ce=0: all registers hold, including strobe_out. strobe_in and I_in/Q_in are ignored.
// - Back-to-back strobes (strobe_in high on consecutive cycles) are legal; each cycle is one sample.
// - I and Q always share the same phase counter and strobe.
// - rst mid-group: the partial sum is discarded and the next accepted sample starts a new group at phase 0.
// - fmt() narrows the DATA_WIDTH+2 bit sum to DATA_WIDTH bits; see CONFIGURATION.
// CONFIGURATION
// - Macro IQ_4SUM_SAT_EN:
//   - Defined: fmt() saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
//   - Undefined: fmt() keeps the low DATA_WIDTH bits (two's-complement wrap). No other behaviour differs.
// TESTING
// - rst then ce=0, strobe_in every 10 clks, I_in=Q_in=15
//   -> strobe_out stays 0; I4sum=Q4sum=0.
// - ce=1, I_in=Q_in=15, strobe_in 1 clk in every 10
//   -> strobe_out pulses 1 clk every 40 clks; I4sum=Q4sum=60.
// - ce=1, I_in=17,0,-17,0 on successive strobes, Q_in=0
//   -> I4sum=0, Q4sum=0 on each group strobe.
// - I_in=32767, Q_in=-32768 for 4 strobes
//   -> with IQ_4SUM_SAT_EN: I4sum=32767, Q4sum=-32768.
//   -> without it: I4sum=-4, Q4sum=0.
// - Group I=5,5 then rst, then 4 strobes of I=5
//   -> first strobe_out after those 4 strobes, I4sum=20.
// - ce dropped to 0 for 20 clks after 2 strobes, then 2 more strobes with ce=1, I=3
//   -> one strobe_out, I4sum=12; strobe_out never asserted while ce=0.

Source files
------------

// File: rtl/iq_4sum.sv
// iq_4sum: decimate-by-4 summer for a complex (I/Q) sample stream.
//
// Every accepted sample (ce=1, strobe_in=1) is added into a per-channel
// accumulator that is DATA_WIDTH+2 bits wide, so four full-scale samples
// can never overflow internally. On the fourth sample of a group the sum is
// narrowed to DATA_WIDTH bits, registered onto I4sum/Q4sum, and strobe_out
// pulses for one clock.
//
// Configuration macro IQ_4SUM_SAT_EN:
//   defined   - narrowing saturates to the signed DATA_WIDTH range
//   undefined - narrowing keeps the low DATA_WIDTH bits (two's-complement wrap)
//
// ce=0 freezes every register, including strobe_out.

module iq_4sum #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  strobe_in,
    input  logic [DATA_WIDTH-1:0] I_in,
    input  logic [DATA_WIDTH-1:0] Q_in,
    output logic [DATA_WIDTH-1:0] I4sum,
    output logic [DATA_WIDTH-1:0] Q4sum,
    output logic                  strobe_out
);

    // Two guard bits cover the growth of summing four samples.
    localparam int unsigned AccWidth = DATA_WIDTH + 2;

`ifdef IQ_4SUM_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    // Position of the next accepted sample within its group of four.
    typedef enum logic [1:0] {
        StPh0 = 2'd0,
        StPh1 = 2'd1,
        StPh2 = 2'd2,
        StPh3 = 2'd3
    } phase_e;

    phase_e                phase_q, phase_d;
    logic [AccWidth-1:0]   i_acc_q, i_acc_d;
    logic [AccWidth-1:0]   q_acc_q, q_acc_d;
    logic [DATA_WIDTH-1:0] i_sum_q, i_sum_d;
    logic [DATA_WIDTH-1:0] q_sum_q, q_sum_d;
    logic                  strobe_q, strobe_d;

    logic [AccWidth-1:0]   i_ext, q_ext;
    logic [AccWidth-1:0]   i_total, q_total;

    // Narrow a full-precision group sum to the output width. The sum is in
    // range exactly when its top three bits agree; otherwise either clamp
    // toward the sign of the sum or let the low bits wrap.
    function automatic logic [DATA_WIDTH-1:0] fmt(input logic [AccWidth-1:0] s);
        logic in_range;
        in_range = (s[AccWidth-1:DATA_WIDTH-1] == {3{s[AccWidth-1]}});
        if (SatEn && !in_range) begin
            if (s[AccWidth-1]) begin
                fmt = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                fmt = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end else begin
            fmt = s[DATA_WIDTH-1:0];
        end
    endfunction

    // Sign-extend the inputs and form the running sum including this sample.
    always_comb begin
        i_ext   = {{2{I_in[DATA_WIDTH-1]}}, I_in};
        q_ext   = {{2{Q_in[DATA_WIDTH-1]}}, Q_in};
        i_total = i_acc_q + i_ext;
        q_total = q_acc_q + q_ext;
    end

    // Next-state: accumulate per phase, publish and pulse on the fourth sample.
    always_comb begin
        phase_d  = phase_q;
        i_acc_d  = i_acc_q;
        q_acc_d  = q_acc_q;
        i_sum_d  = i_sum_q;
        q_sum_d  = q_sum_q;
        strobe_d = strobe_q;

        if (ce) begin
            strobe_d = 1'b0;
            if (strobe_in) begin
                unique case (phase_q)
                    StPh0: begin
                        // First sample of a group replaces whatever was left.
                        i_acc_d = i_ext;
                        q_acc_d = q_ext;
                        phase_d = StPh1;
                    end
                    StPh1: begin
                        i_acc_d = i_total;
                        q_acc_d = q_total;
                        phase_d = StPh2;
                    end
                    StPh2: begin
                        i_acc_d = i_total;
                        q_acc_d = q_total;
                        phase_d = StPh3;
                    end
                    StPh3: begin
                        i_sum_d  = fmt(i_total);
                        q_sum_d  = fmt(q_total);
                        strobe_d = 1'b1;
                        i_acc_d  = '0;
                        q_acc_d  = '0;
                        phase_d  = StPh0;
                    end
                    default: begin
                        phase_d = StPh0;
                    end
                endcase
            end
        end
    end

    // State registers; reset discards any partial group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= StPh0;
            i_acc_q  <= '0;
            q_acc_q  <= '0;
            i_sum_q  <= '0;
            q_sum_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            i_acc_q  <= i_acc_d;
            q_acc_q  <= q_acc_d;
            i_sum_q  <= i_sum_d;
            q_sum_q  <= q_sum_d;
            strobe_q <= strobe_d;
        end
    end

    assign I4sum      = i_sum_q;
    assign Q4sum      = q_sum_q;
    assign strobe_out = strobe_q;

endmodule

// File: tb/tb_iq_4sum.sv
// Self-checking bench for iq_4sum: a behavioural group-sum model compared
// against the DUT on every falling edge, plus literal expectations per scenario.

module tb_iq_4sum;

    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ce;
    logic                 strobe_in;
    logic signed [DW-1:0] i_in;
    logic signed [DW-1:0] q_in;
    logic signed [DW-1:0] i4sum;
    logic signed [DW-1:0] q4sum;
    logic                 strobe_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iq_4sum #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .strobe_in (strobe_in),
        .I_in      (i_in),
        .Q_in      (q_in),
        .I4sum     (i4sum),
        .Q4sum     (q4sum),
        .strobe_out(strobe_out)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Narrowing rule applied to an exact integer sum.
    function automatic int fmt_model(input int s);
        int mx;
        int mn;
        int w;
        mx = (1 <<< (DW - 1)) - 1;
        mn = -(1 <<< (DW - 1));
`ifdef IQ_4SUM_SAT_EN
        if (s > mx) return mx;
        if (s < mn) return mn;
        return s;
`else
        w = s % (1 <<< DW);
        if (w > mx) w -= (1 <<< DW);
        if (w < mn) w += (1 <<< DW);
        return w;
`endif
    endfunction

    // Behavioural model: count samples, sum them as integers, publish on the fourth.
    int m_cnt;
    int m_isum;
    int m_qsum;
    int m_i;
    int m_q;
    bit m_strobe;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_isum = 0; m_qsum = 0;
            m_i = 0; m_q = 0; m_strobe = 1'b0;
        end else if (ce) begin
            m_strobe = 1'b0;
            if (strobe_in) begin
                m_isum += int'(i_in);
                m_qsum += int'(q_in);
                m_cnt++;
                if (m_cnt == 4) begin
                    m_i = fmt_model(m_isum);
                    m_q = fmt_model(m_qsum);
                    m_strobe = 1'b1;
                    m_cnt = 0; m_isum = 0; m_qsum = 0;
                end
            end
        end
    end

    // Compare every cycle, and log strobe pulses for the literal checks.
    int cyc_n = 0;
    int strobe_seen = 0;
    int last_strobe_cyc = 0;
    int prev_strobe_cyc = 0;

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        check("strobe_out", longint'(strobe_out), longint'(m_strobe));
        check("I4sum", longint'(i4sum), longint'(m_i));
        check("Q4sum", longint'(q4sum), longint'(m_q));
        if (strobe_out === 1'b1) begin
            strobe_seen++;
            prev_strobe_cyc = last_strobe_cyc;
            last_strobe_cyc = cyc_n;
        end
    end

    // Drive one cycle of inputs; called 1 time unit after a rising edge.
    task automatic cyc(input logic s, input int i, input int q);
        strobe_in = s;
        i_in      = DW'(i);
        q_in      = DW'(q);
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    int s0;

    initial begin
        rst = 1'b0; ce = 1'b0; strobe_in = 1'b0; i_in = '0; q_in = '0;
        @(posedge clk);
        #1;
        do_rst();
        check("reset I4sum", longint'(i4sum), 0);
        check("reset strobe_out", longint'(strobe_out), 0);

        // ce=0: strobes ignored entirely.
        for (int k = 0; k < 40; k++) cyc(k % 10 == 0, 15, 15);
        check("ce0 strobe count", strobe_seen, 0);
        check("ce0 I4sum", longint'(i4sum), 0);
        check("ce0 Q4sum", longint'(q4sum), 0);

        // Sparse strobes: one pulse per 40 clocks, sum 60.
        ce = 1'b1;
        s0 = strobe_seen;
        for (int k = 0; k < 80; k++) cyc(k % 10 == 0, 15, 15);
        check("sparse strobe count", strobe_seen - s0, 2);
        check("sparse strobe period", last_strobe_cyc - prev_strobe_cyc, 40);
        check("sparse I4sum", longint'(i4sum), 60);
        check("sparse Q4sum", longint'(q4sum), 60);

        // Back-to-back, cancelling I samples.
        cyc(1, 17, 0); cyc(1, 0, 0); cyc(1, -17, 0); cyc(1, 0, 0);
        check("cancel I4sum", longint'(i4sum), 0);
        check("cancel Q4sum", longint'(q4sum), 0);
        check("cancel strobe", longint'(strobe_out), 1);
        // ce=0 right after a group holds strobe_out high.
        ce = 1'b0;
        for (int k = 0; k < 3; k++) cyc(1, 99, 99);
        check("hold strobe ce0", longint'(strobe_out), 1);
        ce = 1'b1;
        cyc(0, 0, 0);
        check("strobe drops", longint'(strobe_out), 0);

        // Full-scale extremes.
        for (int k = 0; k < 4; k++) cyc(1, 32767, -32768);
`ifdef IQ_4SUM_SAT_EN
        check("fullscale I4sum", longint'(i4sum), 32767);
        check("fullscale Q4sum", longint'(q4sum), -32768);
`else
        check("fullscale I4sum", longint'(i4sum), -4);
        check("fullscale Q4sum", longint'(q4sum), 0);
`endif
        cyc(0, 0, 0);

        // Reset mid-group discards the partial sum.
        cyc(1, 5, 0); cyc(1, 5, 0);
        do_rst();
        check("midrst I4sum", longint'(i4sum), 0);
        s0 = strobe_seen;
        cyc(1, 5, 0); cyc(1, 5, 0); cyc(1, 5, 0);
        check("midrst no early strobe", strobe_seen - s0, 0);
        cyc(1, 5, 0);
        check("midrst strobe", longint'(strobe_out), 1);
        check("midrst I4sum 20", longint'(i4sum), 20);
        cyc(0, 0, 0);

        // ce gap inside a group.
        cyc(1, 3, 0); cyc(1, 3, 0);
        ce = 1'b0;
        s0 = strobe_seen;
        for (int k = 0; k < 20; k++) cyc(k % 3 == 0, 3, 0);
        check("ce gap no strobe", strobe_seen - s0, 0);
        ce = 1'b1;
        cyc(1, 3, 0); cyc(1, 3, 0);
        check("ce gap I4sum", longint'(i4sum), 12);
        cyc(0, 0, 0); cyc(0, 0, 0);
        check("ce gap one strobe", strobe_seen - s0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
